mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mul_start  in  1  MULT issue; high one cycle.
- mul_signed  in  1  1 = signed operands, 0 = unsigned.
- op_a  in  32  multiplicand.
- op_b  in  32  multiplier.
- reg_to_mul  in  2  00 none, 01 MTLO, 10 MTHI, 11 ignored.
- wr_data  in  32  MTLO/MTHI data.
- mul_to_reg  in  1  MFLO/MFHI read request.
- mul_read  in  1  read select: 0 LO, 1 HI.
- rd_data  out  32  selected HI/LO value.
- busy  out  1  multiply in progress.
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle completion pulse.
REQ-002 SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-003 SHALL implement FSM states IDLE, CALC, FIN; CALC holds a 6-bit iteration counter.
REQ-004 In IDLE, mul_start=1 at an edge SHALL latch operands (magnitudes when signed), record result sign (sign(op_a) XOR sign(op_b)), clear the 64-bit accumulator and counter, and enter CALC.
REQ-005 Each CALC edge SHALL perform one shift-add step on one multiplier bit, LSB first, and increment the counter; after the 32nd step the FSM SHALL enter FIN.
REQ-006 The FIN edge SHALL write HI = product[63:32], LO = product[31:0] (two's-complement negated when result sign=1), return to IDLE, and set done high for the following cycle only.
REQ-007 Latency: mul_start sampled at edge E0; HI/LO updated at edge E33; done high in the cycle after E33.
REQ-008 busy SHALL equal (state != IDLE), combinationally.
REQ-009 stall SHALL equal busy AND (mul_start OR mul_to_reg OR reg_to_mul != 00).
REQ-010 mul_start while busy SHALL be ignored; no operand or state change occurs.
REQ-011 reg_to_mul=01/10 in IDLE SHALL write wr_data to LO/HI at the edge; it SHALL be ignored while busy.
REQ-012 mul_start and reg_to_mul!=00 in the same IDLE cycle: mul_start SHALL win; the write is dropped.
REQ-013 rd_data SHALL be combinational: HI if mul_read=1, else LO, from registered values, no bypass of same-cycle writes.
REQ-014 A product of 0 (either operand 0) SHALL take the full 33-cycle latency.

Reset
REQ-015 rst high SHALL immediately force: state IDLE, counter 0, accumulator 0, HI=0, LO=0, done=0; therefore busy=0, stall=0, rd_data=0.
REQ-016 Reset mid-CALC/FIN SHALL abort the operation; no done pulse and no HI/LO write SHALL follow.

Configuration
REQ-017 Macro MUL_SIGNED_EN defined: mul_signed SHALL be honoured per REQ-004/006.
REQ-018 MUL_SIGNED_EN undefined: mul_signed SHALL be ignored; all products are unsigned; the sign logic SHALL be absent.

Verification
REQ-019 Bench SHALL cover:
- 7 x 6 unsigned -> busy for 33 cycles, done 1 cycle, HI=0x00000000, LO=0x0000002A.
- 0xFFFFFFFF x 0xFFFFFFFF unsigned -> HI=0xFFFFFFFE, LO=0x00000001.
- -3 x 5 signed -> with MUL_SIGNED_EN: HI=0xFFFFFFFF, LO=0xFFFFFFF1; without: HI=0x00000004, LO=0xFFFFFFF1.
- mul_to_reg=1, mul_read=1 at CALC cycle 5 -> stall=1 until done; then rd_data = new HI.
- rst pulse at CALC cycle 10 -> busy=0, HI=LO=0 at once; no done pulse over the next 40 cycles.
- MTLO 0x00001234 in IDLE, then MTHI while busy -> LO=0x00001234 next cycle; HI unchanged, stall=1 during busy.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential 32x32 multiplier with HI/LO result registers.
//
// One shift-add step per cycle, multiplier LSB first. A multiply issued at
// edge E0 writes HI/LO at edge E33 and pulses done for the following cycle.
// While a multiply is in flight, new issues and HI/LO writes are ignored, and
// stall is raised for any instruction that would touch the unit.
//
// Configuration:
//   MUL_SIGNED_EN  defined   -> mul_signed selects signed operands.
//                  undefined -> all products unsigned, mul_signed ignored.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   mul_start   MULT issue (one-cycle pulse)
//   mul_signed  1 = signed operands (only with MUL_SIGNED_EN)
//   op_a, op_b  multiplicand / multiplier
//   reg_to_mul  00 none, 01 MTLO, 10 MTHI, 11 ignored
//   wr_data     MTLO/MTHI data
//   mul_to_reg  MFLO/MFHI read request
//   mul_read    read select: 0 LO, 1 HI
//   rd_data     registered HI or LO (no same-cycle bypass)
//   busy        multiply in progress
//   stall       pipeline hold request
//   done        one-cycle completion pulse
module mul_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_start,
  input  logic        mul_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [1:0]  reg_to_mul,
  input  logic [31:0] wr_data,
  input  logic        mul_to_reg,
  input  logic        mul_read,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [31:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] product;

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic start_neg;

  // Operate on magnitudes; the result sign is reapplied when HI/LO are written.
  assign a_mag     = (mul_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign b_mag     = (mul_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
  assign start_neg = mul_signed & (op_a[31] ^ op_b[31]);
  assign product   = neg_q ? (~acc_q + 64'd1) : acc_q;
`else
  logic sign_unused;

  assign sign_unused = mul_signed;
  assign a_mag       = op_a;
  assign b_mag       = op_b;
  assign product     = acc_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        // An issue takes priority over a same-cycle MTLO/MTHI, which is dropped.
        if (mul_start) begin
          mcand_d  = {32'd0, a_mag};
          mplier_d = b_mag;
          acc_d    = 64'd0;
          cnt_d    = 6'd0;
`ifdef MUL_SIGNED_EN
          neg_d    = start_neg;
`endif
          state_d  = StCalc;
        end else if (reg_to_mul == 2'b01) begin
          lo_d = wr_data;
        end else if (reg_to_mul == 2'b10) begin
          hi_d = wr_data;
        end
      end
      StCalc: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StFin;
        end
      end
      StFin: begin
        hi_d    = product[63:32];
        lo_d    = product[31:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy    = (state_q != StIdle);
  assign stall   = busy & (mul_start | mul_to_reg | (reg_to_mul != 2'b00));
  assign rd_data = mul_read ? hi_q : lo_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed cases plus random multiplies
// compared against an arithmetic reference product.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mul_start = 1'b0;
  logic        mul_signed = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [1:0]  reg_to_mul = 2'b00;
  logic [31:0] wr_data = 32'd0;
  logic        mul_to_reg = 1'b0;
  logic        mul_read = 1'b0;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        done;

  int checks = 0;
  int failures = 0;

  mul_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mul_start  (mul_start),
    .mul_signed (mul_signed),
    .op_a       (op_a),
    .op_b       (op_b),
    .reg_to_mul (reg_to_mul),
    .wr_data    (wr_data),
    .mul_to_reg (mul_to_reg),
    .mul_read   (mul_read),
    .rd_data    (rd_data),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
`ifdef MUL_SIGNED_EN
    if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`endif
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_hilo(output logic [31:0] hi, output logic [31:0] lo);
    mul_read = 1'b0;
    #1 lo = rd_data;
    mul_read = 1'b1;
    #1 hi = rd_data;
    mul_read = 1'b0;
  endtask

  // Count cycles with busy high (bounded); note any done seen while busy.
  task automatic wait_busy(output int n, output int done_in_busy);
    n = 0;
    done_in_busy = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (done === 1'b1) done_in_busy++;
      tick();
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag);
    int n, dd;
    logic [31:0] hi, lo;
    logic [63:0] exp;
    exp = model(a, b, s);
    op_a = a;
    op_b = b;
    mul_signed = s;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    mul_signed = ~s;
    wait_busy(n, dd);
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_early"}, 64'(dd), 64'd0);
    rd_hilo(hi, lo);
    chk({tag, "_hi"}, 64'(hi), {32'd0, exp[63:32]});
    chk({tag, "_lo"}, 64'(lo), {32'd0, exp[31:0]});
    tick();
    chk({tag, "_done_fall"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, dd, bad;
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;
    logic s;

    // Reset state, including stall suppression while a request is present.
    #1 rst = 1'b1;
    mul_start = 1'b1;
    mul_to_reg = 1'b1;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rd_hilo(hi, lo);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    tick();
    tick();
    chk("rst_hold_busy", 64'(busy), 64'd0);
    mul_start = 1'b0;
    mul_to_reg = 1'b0;
    rst = 1'b0;
    tick();

    // Directed products.
    run_mul(32'd7, 32'd6, 1'b0, "mul_7x6");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_ffxff");
    chk("ffxff_const", model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0),
        64'hFFFF_FFFE_0000_0001);
    run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, "mul_m3x5");
    rd_hilo(hi, lo);
`ifdef MUL_SIGNED_EN
    chk("m3x5_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    chk("m3x5_hilo", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif
    run_mul(32'd0, 32'h1234_5678, 1'b0, "mul_zero_a");
    run_mul(32'h8765_4321, 32'd0, 1'b1, "mul_zero_b");

    // Read request during CALC: stall until completion, then the new HI.
    a = $urandom;
    b = $urandom;
    exp = model(a, b, 1'b0);
    op_a = a;
    op_b = b;
    mul_signed = 1'b0;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mul_to_reg = 1'b1;
    mul_read = 1'b1;
    #1;
    chk("mf_stall_c5", 64'(stall), 64'd1);
    bad = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (stall !== 1'b1) bad++;
      tick();
    end
    chk("mf_stall_hold", 64'(bad), 64'd0);
    chk("mf_busy_end", 64'(busy), 64'd0);
    chk("mf_stall_end", 64'(stall), 64'd0);
    chk("mf_rd_hi", 64'(rd_data), {32'd0, exp[63:32]});
    mul_to_reg = 1'b0;
    mul_read = 1'b0;
    tick();

    // Reset in the middle of CALC aborts the multiply.
    op_a = 32'h0001_0001;
    op_b = 32'h0003_0003;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    mul_to_reg = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    rd_hilo(hi, lo);
    chk("abort_hilo", {hi, lo}, 64'd0);
    mul_to_reg = 1'b0;
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) n++;
      tick();
    end
    chk("abort_no_done", 64'(n), 64'd0);
    rd_hilo(hi, lo);
    chk("abort_hilo_after", {hi, lo}, 64'd0);

    // MTLO in IDLE (no bypass), then MTHI while busy is ignored.
    reg_to_mul = 2'b01;
    wr_data = 32'h0000_1234;
    #1;
    chk("mtlo_no_bypass", 64'(rd_data), 64'd0);
    tick();
    reg_to_mul = 2'b00;
    rd_hilo(hi, lo);
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi", 64'(hi), 64'd0);
    op_a = 32'h0001_0000;
    op_b = 32'h0003_0000;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    tick();
    reg_to_mul = 2'b10;
    wr_data = 32'hDEAD_BEEF;
    #1;
    chk("mthi_busy_stall", 64'(stall), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    rd_hilo(hi, lo);
    chk("mthi_busy_hi", 64'(hi), 64'd0);
    chk("mthi_busy_lo", 64'(lo), 64'h1234);
    reg_to_mul = 2'b00;
    wait_busy(n, dd);
    rd_hilo(hi, lo);
    chk("mthi_result", {hi, lo}, 64'h0000_0003_0000_0000);
    tick();

    // Issue beats a same-cycle MTLO; a second issue while busy is ignored.
    op_a = 32'd5;
    op_b = 32'd9;
    mul_start = 1'b1;
    reg_to_mul = 2'b01;
    wr_data = 32'h0000_AAAA;
    tick();
    reg_to_mul = 2'b00;
    mul_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    op_a = 32'hFFFF_FFFF;
    op_b = 32'hFFFF_FFFF;
    mul_start = 1'b1;
    #1;
    chk("reissue_stall", 64'(stall), 64'd1);
    tick();
    mul_start = 1'b0;
    wait_busy(n, dd);
    chk("reissue_latency", 64'(n), 64'd29);
    rd_hilo(hi, lo);
    chk("reissue_result", {hi, lo}, 64'd45);
    tick();

    // Random operands and signedness.
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i == 0) a = 32'h8000_0000;
      run_mul(a, b, s, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
